// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI (mode 0) slave that emulates the read side of a serial NOR flash.
//   Supported opcodes: 0x03 (read, 24-bit address, auto-incrementing),
//   0x9F (JEDEC ID, then 0xFF), 0x05 (status byte, repeated). Any other
//   opcode is ignored until CS rises. Memory is read through a one-cycle
//   strobe; read data is expected in the cycle following the strobe.
//
// Ports
//   clk_48mhz    in   system clock, all state on its rising edge
//   rst_n        in   asynchronous active-low reset
//   spi_cs       in   SPI chip select, active-low, asynchronous
//   spi_sck      in   SPI clock (mode 0), asynchronous
//   spi_mosi     in   SPI data from master
//   spi_miso     out  SPI data to master (idles high)
//   spi_miso_oe  out  MISO output enable, high while a response is shifted
//   mem_rd       out  one-cycle read strobe to backing memory
//   mem_addr     out  byte address, valid with mem_rd
//   mem_rdata    in   read data, valid the cycle after mem_rd
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        clk_48mhz,
    input  logic        rst_n,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

    // Synchronizers plus one extra stage for edge detection
    logic cs_s1, cs_s2, cs_d;
    logic sck_s1, sck_s2, sck_d;
    logic mosi_s1, mosi_s2;
    // CS must be seen high once after reset before a falling edge counts,
    // so a transaction interrupted by reset is never picked up again.
    logic cs_armed;

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_d     <= 1'b1;
            sck_s1   <= 1'b0;
            sck_s2   <= 1'b0;
            sck_d    <= 1'b0;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            cs_armed <= 1'b0;
        end else begin
            cs_s1    <= spi_cs;
            cs_s2    <= cs_s1;
            cs_d     <= cs_s2;
            sck_s1   <= spi_sck;
            sck_s2   <= sck_s1;
            sck_d    <= sck_s2;
            mosi_s1  <= spi_mosi;
            mosi_s2  <= mosi_s1;
            cs_armed <= cs_armed | cs_s2;
        end
    end

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    always_comb begin
        cs_fall  = cs_d & ~cs_s2 & cs_armed;
        cs_rise  = ~cs_d & cs_s2;
        sck_rise = sck_s2 & ~sck_d & ~cs_s2;
        sck_fall = ~sck_s2 & sck_d & ~cs_s2;
    end

    state_t      state;
    src_t        src;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [1:0]  id_idx;
    logic [6:0]  rx_sr;
    logic [22:0] addr_sr;
    logic [7:0]  tx_sr;
    logic [1:0]  rd_pipe;   // [1] set in the cycle mem_rdata is valid

    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic [7:0]  id_next;

    always_comb begin
        cmd_byte  = {rx_sr, mosi_s2};
        addr_full = {addr_sr, mosi_s2};
        case (id_idx)
            2'd1:    id_next = JEDEC_ID[15:8];
            2'd2:    id_next = JEDEC_ID[7:0];
            default: id_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src         <= SRC_MEM;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            id_idx      <= '0;
            rx_sr       <= '0;
            addr_sr     <= '0;
            tx_sr       <= '1;
            rd_pipe     <= '0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pipe <= {rd_pipe[0], 1'b0};
            if (rd_pipe[1])
                tx_sr <= mem_rdata;

            if (cs_rise) begin
                state       <= IDLE;
                spi_miso    <= 1'b1;
                spi_miso_oe <= 1'b0;
                bit_cnt     <= '0;
                rd_pipe     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso    <= 1'b1;
                        spi_miso_oe <= 1'b0;
                        if (cs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (sck_rise) begin
                            rx_sr   <= cmd_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (cmd_byte)
                                    8'h03: begin
                                        state    <= ADDR;
                                        byte_cnt <= '0;
                                    end
                                    8'h9F: begin
                                        state  <= DATA;
                                        src    <= SRC_ID;
                                        tx_sr  <= JEDEC_ID[23:16];
                                        id_idx <= 2'd1;
                                    end
                                    8'h05: begin
                                        state <= DATA;
                                        src   <= SRC_STATUS;
                                        tx_sr <= STATUS_VAL;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end

                    ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_full[22:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                                if (byte_cnt == 2'd2) begin
                                    mem_rd   <= 1'b1;
                                    mem_addr <= addr_full;
                                    rd_pipe  <= 2'b01;
                                    src      <= SRC_MEM;
                                    state    <= DATA;
                                end
                            end
                        end
                    end

                    DATA: begin
                        // Shift out on the falling edge; the byte register is
                        // refilled after the 8th rising edge of each byte.
                        if (sck_fall) begin
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= tx_sr[7];
                            tx_sr       <= {tx_sr[6:0], 1'b1};
                        end
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (src)
                                    SRC_MEM: begin
                                        mem_addr <= mem_addr + 24'd1;
                                        mem_rd   <= 1'b1;
                                        rd_pipe  <= 2'b01;
                                    end
                                    SRC_ID: begin
                                        tx_sr <= id_next;
                                        if (id_idx != 2'd3)
                                            id_idx <= id_idx + 2'd1;
                                    end
                                    default: tx_sr <= STATUS_VAL;
                                endcase
                            end
                        end
                    end

                    IGNORE: begin
                        spi_miso    <= 1'b1;
                        spi_miso_oe <= 1'b0;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 The module SHALL provide parameter JEDEC_ID, default 24'hEF4016, as the three ID bytes returned MSB-byte first by opcode 0x9F.
REQ-002 The module SHALL provide parameter STATUS_VAL, default 8'h00, as the byte returned by opcode 0x05.
REQ-003 Port clk_48mhz, input, 1: the only clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port spi_cs, input, 1: chip select from the SPI master, active-low, asynchronous to clk_48mhz.
REQ-006 Port spi_sck, input, 1: SPI clock, mode 0, asynchronous to clk_48mhz.
REQ-007 Port spi_mosi, input, 1: serial data from the master.
REQ-008 Port spi_miso, output, 1: serial data to the master.
REQ-009 Port spi_miso_oe, output, 1: MISO output enable, high only while a response byte is being shifted.
REQ-010 Port mem_rd, output, 1: one-cycle read strobe to the backing memory.
REQ-011 Port mem_addr, output, 24: byte address, valid while mem_rd is high.
REQ-012 Port mem_rdata, input, 8: read data, valid exactly one clk_48mhz cycle after mem_rd.

Function
REQ-013 spi_cs, spi_sck and spi_mosi SHALL each pass through a 2-flop synchronizer; SCK edges SHALL be detected from the synchronized SCK.
REQ-014 Supported timing: SCK high time and low time each at least 4 clk_48mhz cycles; CS setup and hold to SCK each at least 4 cycles.
REQ-015 MOSI SHALL be sampled on each detected SCK rising edge, MSB first.
REQ-016 MISO SHALL be updated within 1 cycle after each detected SCK falling edge, MSB first.
REQ-017 State machine states: IDLE, CMD, ADDR, DATA, IGNORE.
REQ-018 Synchronized CS falling edge in IDLE: go to CMD, clear the 3-bit bit counter, drive spi_miso_oe low.
REQ-019 On the 8th rising edge in CMD, the opcode is decoded:
- 0x03 -> ADDR
- 0x9F -> DATA with ID source
- 0x05 -> DATA with status source
- 0xAB or any other opcode -> IGNORE
REQ-020 ADDR SHALL shift 24 address bits. On the 24th rising edge, the block SHALL issue mem_rd=1 for one cycle with mem_addr equal to the shifted address, then enter DATA.
REQ-021 The memory byte SHALL be captured into the TX shift register one cycle after mem_rd, before the next SCK falling edge.
REQ-022 In DATA, spi_miso_oe SHALL be 1 from the first falling edge after the last command/address bit until CS rises.
REQ-023 Read source: after each 8th rising edge of a data byte, mem_addr SHALL increment modulo 2^24 and mem_rd SHALL be pulsed again, so the next byte is ready before the following falling edge. 24'hFFFFFF wraps to 24'h000000.
REQ-024 ID source: return JEDEC_ID[23:16], [15:8], [7:0], then 8'hFF for every later byte.
REQ-025 Status source: return STATUS_VAL repeatedly for as long as clocks continue.
REQ-026 In IGNORE, spi_miso_oe SHALL be 0 and spi_miso SHALL be 1; MOSI SHALL be ignored.
REQ-027 Synchronized CS rising edge in any state SHALL, within 1 cycle:
- return the FSM to IDLE
- drive spi_miso_oe=0 and spi_miso=1
- clear the bit counter
- leave mem_rd at 0 (any partial byte or partial address is discarded)
REQ-028 An SCK edge detected while synchronized CS is high SHALL be ignored.
REQ-029 mem_rd SHALL never be high for two consecutive cycles.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: spi_miso=1, spi_miso_oe=0, mem_rd=0, mem_addr=24'h000000; the FSM SHALL be in IDLE and the synchronizers SHALL be preset to CS=1, SCK=0.
REQ-031 rst_n asserted mid-transaction SHALL abort the transaction. After release, the block SHALL wait for a fresh CS falling edge and SHALL NOT resume.

Verification
REQ-032 Read ID: CS low, opcode 0x9F, 32 clocks -> MISO bytes EF 40 16 FF; spi_miso_oe=1 only during the response bytes.
REQ-033 Read: opcode 0x03, address 00_01_00, 3 data bytes, memory model returns addr[7:0]^8'hA5 -> mem_rd pulses with mem_addr 000100, 000101, 000102, 000103; MISO bytes A5 A4 A7.
REQ-034 Wrap: opcode 0x03, address FF_FF_FF, 2 data bytes -> mem_addr sequence FFFFFF, 000000; data bytes match the memory model.
REQ-035 Abort: CS rises after 13 address bits of a 0x03 command -> no mem_rd pulse; spi_miso_oe=0 within 3 cycles of the CS pin edge; a following 0x9F transaction returns EF 40 16.
REQ-036 Unknown opcode 0x5A followed by 16 clocks -> spi_miso_oe stays 0, spi_miso stays 1, no mem_rd pulse.
REQ-037 rst_n pulsed low for 2 cycles in the middle of a 0x05 response -> outputs take reset values immediately; after CS cycles high then low, opcode 0x05 returns 00.
